// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressed little-endian data memory with a
// fixed-latency, single-outstanding valid/ready request/response port.
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 131072,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ready;
  logic                  r_we;
  logic [AW-1:0]         r_idx;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic [7:0] r_mem [MEM_BYTES];

  logic                  w_legal;
  logic                  w_fire;
  logic                  w_commit;
  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [7:0]            w_b3;
  logic [DATA_WIDTH-1:0] w_load;
  logic                  w_unused_addr;

  // Upper address bits wrap silently onto the array.
  assign w_unused_addr = ^req_addr[31:AW];

  assign w_b0 = r_mem[r_idx];
  assign w_b1 = r_mem[r_idx + AW'(1)];
  assign w_b2 = r_mem[r_idx + AW'(2)];
  assign w_b3 = r_mem[r_idx + AW'(3)];

  assign w_fire   = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_commit = w_fire && r_we && w_legal;

  // Width code and alignment legality of the captured request.
  always_comb begin
    w_legal = 1'b0;
    unique case (r_f3)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = ~r_idx[0];
      3'b010:  w_legal = (r_idx[1:0] == 2'b00);
      3'b100:  w_legal = ~r_we;
      3'b101:  w_legal = ~r_we & ~r_idx[0];
      default: w_legal = 1'b0;
    endcase
  end

  // Load result with sign or zero extension.
  always_comb begin
    w_load = '0;
    unique case (r_f3)
      3'b000:  w_load = {{24{w_b0[7]}}, w_b0};
      3'b001:  w_load = {{16{w_b1[7]}}, w_b1, w_b0};
      3'b010:  w_load = {w_b3, w_b2, w_b1, w_b0};
      3'b100:  w_load = {24'd0, w_b0};
      3'b101:  w_load = {16'd0, w_b1, w_b0};
      default: w_load = '0;
    endcase
  end

  // Store commit; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_wdata[7:0];
      if (r_f3 != 3'b000) begin
        r_mem[r_idx + AW'(1)] <= r_wdata[15:8];
      end
      if (r_f3 == 3'b010) begin
        r_mem[r_idx + AW'(2)] <= r_wdata[23:16];
        r_mem[r_idx + AW'(3)] <= r_wdata[31:24];
      end
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_f3    <= 3'b000;
      r_wdata <= '0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (req_valid && r_ready) begin
            r_we    <= req_we;
            r_idx   <= req_addr[AW-1:0];
            r_f3    <= req_funct3;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_ready <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_err   <= ~w_legal;
            r_rdata <= (r_we || !w_legal) ? '0 : w_load;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of the data
// memory responder against a transaction-level byte-array model.
module tb_data_mem_responder;

  localparam int DW  = 32;
  localparam int MB  = 131072;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DATA_WIDTH(DW),
    .MEM_BYTES(MB),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  // Reference model: byte array plus one outstanding transaction.
  logic [7:0]  mm [int];
  bit          m_out   = 1'b0;
  bit          m_rdy   = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_age   = 0;
  bit          p_we;
  logic [2:0]  p_f3;
  int          p_idx;
  logic [31:0] p_wd;
  bit          p_err;
  logic [31:0] p_rd;

  function automatic logic [7:0] mb(input int i);
    int k;
    k = i % MB;
    return mm.exists(k) ? mm[k] : 8'h00;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_out = 0; m_rdy = 0; m_valid = 0;
      m_rdata = '0; m_err = 0;
    end else if (!m_out) begin
      if (m_rdy && req_valid) begin
        bit ok;
        logic [7:0] b0, b1, b2, b3;
        m_out = 1; m_rdy = 0; m_age = 0;
        p_we = req_we; p_f3 = req_funct3; p_wd = req_wdata;
        p_idx = int'(req_addr % 32'(MB));
        case (p_f3)
          3'd0: ok = 1;
          3'd1: ok = (p_idx % 2) == 0;
          3'd2: ok = (p_idx % 4) == 0;
          3'd4: ok = !p_we;
          3'd5: ok = !p_we && (p_idx % 2) == 0;
          default: ok = 0;
        endcase
        p_err = !ok;
        b0 = mb(p_idx); b1 = mb(p_idx + 1);
        b2 = mb(p_idx + 2); b3 = mb(p_idx + 3);
        p_rd = '0;
        if (!p_we && ok) begin
          case (p_f3)
            3'd0: p_rd = {{24{b0[7]}}, b0};
            3'd1: p_rd = {{16{b1[7]}}, b1, b0};
            3'd2: p_rd = {b3, b2, b1, b0};
            3'd4: p_rd = {24'd0, b0};
            default: p_rd = {16'd0, b1, b0};
          endcase
        end
      end else begin
        m_rdy = 1;
      end
    end else if (!m_valid) begin
      m_age++;
      if (m_age == LAT) begin
        m_valid = 1; m_err = p_err; m_rdata = p_rd;
        if (p_we && !p_err) begin
          int n;
          n = (p_f3 == 3'd0) ? 1 : (p_f3 == 3'd1) ? 2 : 4;
          for (int k = 0; k < n; k++)
            mm[(p_idx + k) % MB] = p_wd[8*k +: 8];
        end
      end
    end else if (resp_ready) begin
      m_valid = 0; m_out = 0; m_rdy = 1;
    end
  end

  // Per-cycle comparison of the DUT against the model.
  initial forever begin
    @(negedge clk);
    chk1("cyc_req_ready", req_ready, m_rdy);
    chk1("cyc_resp_valid", resp_valid, m_valid);
    if (m_valid || !rst) begin
      check("cyc_resp_rdata", resp_rdata, m_rdata);
      chk1("cyc_resp_err", resp_err, m_err);
    end
  end

  task automatic issue(input bit we, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       input bit keep);
    int w;
    w = 0;
    req_valid = 1; req_we = we; req_addr = a;
    req_funct3 = f3; req_wdata = wd;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk1("accept_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 0;
  endtask

  task automatic finish(input string nm, input int hold, input bit lit,
                        input logic [31:0] erd, input bit eerr);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!resp_valid && n < 40);
    check({nm, "_latency"}, n, LAT);
    if (lit) begin
      check({nm, "_rdata"}, resp_rdata, erd);
      chk1({nm, "_err"}, resp_err, eerr);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (lit) begin
        check({nm, "_hold_rdata"}, resp_rdata, erd);
        chk1({nm, "_hold_valid"}, resp_valid, 1'b1);
      end
    end
    req_valid = 0;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk1({nm, "_done_valid"}, resp_valid, 1'b0);
    chk1({nm, "_done_ready"}, req_ready, 1'b1);
  endtask

  task automatic xact(input string nm, input bit we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input int hold, input bit keep, input bit lit,
                      input logic [31:0] erd, input bit eerr);
    issue(we, a, f3, wd, keep);
    finish(nm, hold, lit, erd, eerr);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    rst = 1;
    @(negedge clk);
    chk1("post_rst_ready", req_ready, 1'b1);

    xact("sw100", 1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0, 1, 32'h0, 0);
    xact("lw100", 0, 32'h100, 3'd2, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
    xact("sw200", 1, 32'h200, 3'd2, 32'h80FF7F01, 0, 0, 1, 32'h0, 0);
    xact("lb203", 0, 32'h203, 3'd0, 32'h0, 0, 0, 1, 32'hFFFFFF80, 0);
    xact("lbu203", 0, 32'h203, 3'd4, 32'h0, 0, 0, 1, 32'h00000080, 0);
    xact("lh202", 0, 32'h202, 3'd1, 32'h0, 0, 0, 1, 32'hFFFF80FF, 0);
    xact("lhu200", 0, 32'h200, 3'd5, 32'h0, 0, 0, 1, 32'h00007F01, 0);
    xact("lw102", 0, 32'h102, 3'd2, 32'h0, 0, 0, 1, 32'h0, 1);
    xact("sh101", 1, 32'h101, 3'd1, 32'h5555, 0, 0, 1, 32'h0, 1);
    xact("lw100b", 0, 32'h100, 3'd2, 32'h0, 0, 0, 1, 32'hDEADBEEF, 0);
    xact("f3_011", 0, 32'h100, 3'd3, 32'h0, 0, 0, 1, 32'h0, 1);
    xact("sbu_ill", 1, 32'h100, 3'd4, 32'h77, 0, 0, 1, 32'h0, 1);
    xact("bp5", 0, 32'h200, 3'd2, 32'h0, 5, 1, 1, 32'h80FF7F01, 0);

    xact("sw300", 1, 32'h300, 3'd2, 32'hAAAAAAAA, 0, 0, 1, 32'h0, 0);
    issue(1, 32'h300, 3'd2, 32'h11223344, 0);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk1("rstw_valid", resp_valid, 1'b0);
    chk1("rstw_ready", req_ready, 1'b0);
    check("rstw_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk1("rstw_release_ready", req_ready, 1'b1);

    issue(0, 32'h100, 3'd2, 32'h0, 0);
    w = 0;
    while (!resp_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("rstr_pre_rdata", resp_rdata, 32'hDEADBEEF);
    #2 rst = 0;
    #1;
    chk1("rstr_valid", resp_valid, 1'b0);
    check("rstr_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);

    xact("lw300", 0, 32'h300, 3'd2, 32'h0, 0, 0, 1, 32'hAAAAAAAA, 0);
    xact("sbwrap", 1, 32'(MB + 4), 3'd0, 32'h5A, 0, 0, 1, 32'h0, 0);
    xact("lbu4", 0, 32'h4, 3'd4, 32'h0, 0, 0, 1, 32'h0000005A, 0);

    for (int i = 0; i < 16; i++)
      xact("init", 1, 32'h1000 + 32'(4 * i), 3'd2, $urandom, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFE0000) | (32'h1000 + ($urandom % 64));
      xact("rnd", ($urandom % 3) == 0, a, 3'($urandom % 8), $urandom,
           int'($urandom % 3), bit'($urandom % 2), 0, 0, 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 32, data bus width.
- MEM_BYTES, 131072, byte capacity; power of two.
- LATENCY, 2, cycles from request accept to response; legal range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, reset, asynchronous, active-low.
- req_valid, input, 1, initiator presents a request.
- req_ready, output, 1, responder can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_addr, input, 32, byte address.
- req_funct3, input, 3, RV32I load/store width code.
- req_wdata, input, 32, store data, right-aligned.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, initiator accepts the response.
- resp_rdata, output, 32, load result; 0 for stores and errors.
- resp_err, output, 1, request was misaligned or had an illegal funct3.
REQ-003 The clock SHALL be named clk; the reset SHALL be named rst, asynchronous and active-low (asserted when 0).

Function
REQ-004 FSM states SHALL be IDLE, WAIT and RESP. At most one request SHALL be outstanding.
REQ-005 req_ready SHALL be 1 only in IDLE. A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1, and addr, we, funct3 and wdata SHALL be captured at that edge.
REQ-006 On accept, the FSM SHALL go IDLE->WAIT and load a down-counter with LATENCY-1.
REQ-007 In WAIT, the counter SHALL decrement each cycle. When it is 0, the FSM SHALL go to RESP on the next edge, so resp_valid rises exactly LATENCY edges after the accept edge.
REQ-008 On the WAIT->RESP edge, the memory access SHALL execute: a store writes the selected bytes, and a load registers resp_rdata.
REQ-009 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until an edge with resp_ready=1. That edge SHALL move the FSM to IDLE and clear resp_valid.
REQ-010 No request SHALL be accepted on the same edge that completes a response; the earliest next accept is one cycle later, in IDLE.
REQ-011 funct3 decode SHALL be as follows.
- 000: LB/SB.
- 001: LH/SH.
- 010: LW/SW.
- 100: LBU (load only).
- 101: LHU (load only).
- Any other code, or 100/101 with we=1: illegal, resp_err=1.
REQ-012 Alignment SHALL be checked as follows. Halfword needs addr[0]=0; word needs addr[1:0]=00. A misaligned access SHALL set resp_err=1.
REQ-013 An errored request SHALL NOT modify memory, SHALL return resp_rdata=0, and SHALL still take LATENCY cycles plus the handshake.
REQ-014 Memory SHALL be little-endian and byte-addressed. The byte index SHALL be req_addr modulo MEM_BYTES, so upper address bits wrap silently with no error.
REQ-015 Stores SHALL write these bytes of wdata: [7:0] for SB, [15:0] for SH, all for SW; other memory bytes SHALL be unchanged.
REQ-016 Loads SHALL extend as follows.
- LB/LH: sign-extend to 32 bits.
- LBU/LHU: zero-extend.
- LW: return the 4 bytes unmodified.
REQ-017 For stores, resp_rdata SHALL be 0 and resp_err SHALL be 0 when the store is legal.
REQ-018 Request inputs SHALL be ignored outside IDLE, even if req_valid=1.

Reset
REQ-019 While rst=0, the block SHALL be forced, regardless of clk, to:
- state IDLE;
- counter 0;
- resp_valid 0;
- resp_rdata 0;
- resp_err 0.
REQ-020 req_ready SHALL be 1 from the first edge after rst returns to 1. While rst=0, req_ready SHALL be 0.
REQ-021 Reset asserted mid-operation (WAIT or RESP) SHALL abandon the request.
- A store not yet committed SHALL NOT be written.
- Memory contents SHALL NOT be cleared by reset.

Verification
REQ-022 SW then LW, with LATENCY=2:
- SW at addr 0x100 with wdata 0xDEADBEEF, then LW at 0x100.
- resp_valid SHALL rise 2 edges after each accept.
- The LW SHALL return 0xDEADBEEF with resp_err=0.
REQ-023 Byte/half loads of stored word 0x80FF7F01 at 0x200:
- LB 0x203 -> 0xFFFFFF80.
- LBU 0x203 -> 0x00000080.
- LH 0x202 -> 0xFFFF80FF.
- LHU 0x200 -> 0x00007F01.
REQ-024 Errors:
- LW at 0x102 -> resp_err=1, rdata=0.
- SH at 0x101 -> resp_err=1, and a following LW at 0x100 is unchanged.
- funct3=011 -> resp_err=1.
REQ-025 Backpressure and input masking:
- Hold resp_ready=0 for 5 cycles in RESP: resp_valid, rdata and err stay constant.
- req_valid=1 throughout that time causes no new accept.
- With resp_ready=1, the FSM returns to IDLE and req_ready=1 the next cycle.
REQ-026 Reset mid-store:
- Drive rst=0 in WAIT of an SW 0x11223344 to 0x300 that overwrites 0xAAAAAAAA.
- Outputs clear asynchronously.
- After release, LW 0x300 returns 0xAAAAAAAA.
REQ-027 Wrap: SB 0x5A to address MEM_BYTES+4, then LBU at 4 -> 0x0000005A.
